// File: rtl/dht_request_sequencer_if.sv
// Bundles the command, sensor and response-byte signals of the DHT request sequencer.
// Latency: none, wiring only.
// Backpressure: tx_ready from the consumer stalls response bytes; no other signal carries backpressure.
interface dht_request_sequencer_if;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       sens_start;
  logic       sens_done;
  logic       sens_err;
  logic [7:0] sens_hum_int;
  logic [7:0] sens_hum_float;
  logic [7:0] sens_temp_int;
  logic [7:0] sens_temp_float;
  logic [7:0] sens_crc;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  // Host/sensor/consumer side: issues commands, answers reads, accepts bytes
  modport master (
    output cmd_valid, cmd_byte, sens_done, sens_err,
           sens_hum_int, sens_hum_float, sens_temp_int, sens_temp_float, sens_crc,
           tx_ready,
    input  sens_start, tx_data, tx_valid, busy
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_byte, sens_done, sens_err,
           sens_hum_int, sens_hum_float, sens_temp_int, sens_temp_float, sens_crc,
           tx_ready,
    output sens_start, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/dht_request_sequencer.sv
// Decodes humidity/temperature commands, answers from a rate-limited cache or runs a sensor read, returns 3 bytes.
// Latency: cache hit or bad command -> first byte 2 cycles after cmd_valid; sensor read -> 2 cycles after sens_done.
// Backpressure: each response byte is held until tx_ready; the FSM waits in SENDn indefinitely, commands are dropped while busy.
module dht_request_sequencer #(
  parameter int unsigned MIN_INTERVAL = 100000000,
  parameter int unsigned TIMEOUT      = 5000000
) (
  input  logic                   clk,
  input  logic                   rst,
  dht_request_sequencer_if.slave bus
);

  localparam logic [26:0] IVL_SAT  = 27'(MIN_INTERVAL);
  // WAIT_DONE gives up on the edge where its counter reaches TIMEOUT-1, which
  // places the timeout response exactly TIMEOUT cycles after the START cycle.
  localparam logic [26:0] TMO_LAST = 27'(TIMEOUT - 2);

  localparam logic [7:0] CMD_HUM    = 8'h01;
  localparam logic [7:0] CMD_TEMP   = 8'h02;
  localparam logic [7:0] RSP_FRESH  = 8'h00;
  localparam logic [7:0] RSP_CACHED = 8'h01;
  localparam logic [7:0] RSP_SENS   = 8'hE1;
  localparam logic [7:0] RSP_CRC    = 8'hE2;
  localparam logic [7:0] RSP_TMO    = 8'hE3;
  localparam logic [7:0] RSP_CMD    = 8'hEE;

  typedef enum logic [2:0] {
    IDLE, DECODE, START, WAIT_DONE, CHECK, SEND0, SEND1, SEND2
  } state_t;

  state_t      state, state_nxt;

  logic [7:0]  cmd;
  logic [26:0] ivl_cnt;
  logic [26:0] tmo_cnt;

  logic        cache_valid;
  logic [7:0]  c_hum_int, c_hum_flt, c_tmp_int, c_tmp_flt;

  logic        cap_err;
  logic [7:0]  cap_hum_int, cap_hum_flt, cap_tmp_int, cap_tmp_flt, cap_crc;

  logic [7:0]  rsp0, rsp1, rsp2;

  logic        cmd_ok, cache_hit, tmo_hit, crc_ok, read_good;

  assign cmd_ok    = (cmd == CMD_HUM) || (cmd == CMD_TEMP);
  assign cache_hit = cache_valid && (ivl_cnt < IVL_SAT);
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign crc_ok    = (8'(cap_hum_int + cap_hum_flt + cap_tmp_int + cap_tmp_flt) == cap_crc);
  assign read_good = (state == CHECK) && !cap_err && crc_ok;

  function automatic logic [15:0] pick_pair(input logic [7:0] sel,
                                            input logic [7:0] hi, input logic [7:0] hf,
                                            input logic [7:0] ti, input logic [7:0] tf);
    return (sel == CMD_HUM) ? {hi, hf} : {ti, tf};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: sensor done beats timeout; SENDn advances only on handshake
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.cmd_valid) state_nxt = DECODE;
      DECODE:    state_nxt = (!cmd_ok || cache_hit) ? SEND0 : START;
      START:     state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.sens_done)  state_nxt = CHECK;
        else if (tmo_hit)   state_nxt = SEND0;
      end
      CHECK:     state_nxt = SEND0;
      SEND0:     if (bus.tx_ready) state_nxt = SEND1;
      SEND1:     if (bus.tx_ready) state_nxt = SEND2;
      SEND2:     if (bus.tx_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; the response register is only visible in SENDn
  always_comb begin
    bus.sens_start = 1'b0;
    bus.tx_valid   = 1'b0;
    bus.tx_data    = 8'h00;
    bus.busy       = (state != IDLE);
    case (state)
      START: bus.sens_start = 1'b1;
      SEND0: begin bus.tx_valid = 1'b1; bus.tx_data = rsp0; end
      SEND1: begin bus.tx_valid = 1'b1; bus.tx_data = rsp1; end
      SEND2: begin bus.tx_valid = 1'b1; bus.tx_data = rsp2; end
      default: ;
    endcase
  end

  // Interval since the last good read: free-running, saturating, cleared only by a good read
  always_ff @(posedge clk) begin
    if (rst)                      ivl_cnt <= IVL_SAT;
    else if (read_good)           ivl_cnt <= '0;
    else if (ivl_cnt < IVL_SAT)   ivl_cnt <= ivl_cnt + 27'd1;
  end

  // Command latch, sensor capture, cache update and response formation
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd         <= 8'h00;
      tmo_cnt     <= '0;
      cache_valid <= 1'b0;
      c_hum_int   <= 8'h00;
      c_hum_flt   <= 8'h00;
      c_tmp_int   <= 8'h00;
      c_tmp_flt   <= 8'h00;
      cap_err     <= 1'b0;
      cap_hum_int <= 8'h00;
      cap_hum_flt <= 8'h00;
      cap_tmp_int <= 8'h00;
      cap_tmp_flt <= 8'h00;
      cap_crc     <= 8'h00;
      rsp0        <= 8'h00;
      rsp1        <= 8'h00;
      rsp2        <= 8'h00;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) cmd <= bus.cmd_byte;
        DECODE: begin
          if (!cmd_ok) begin
            rsp0 <= RSP_CMD; rsp1 <= 8'h00; rsp2 <= 8'h00;
          end else if (cache_hit) begin
            rsp0 <= RSP_CACHED;
            {rsp1, rsp2} <= pick_pair(cmd, c_hum_int, c_hum_flt, c_tmp_int, c_tmp_flt);
          end
        end
        START: tmo_cnt <= '0;
        WAIT_DONE: begin
          tmo_cnt <= tmo_cnt + 27'd1;
          if (bus.sens_done) begin
            cap_err     <= bus.sens_err;
            cap_hum_int <= bus.sens_hum_int;
            cap_hum_flt <= bus.sens_hum_float;
            cap_tmp_int <= bus.sens_temp_int;
            cap_tmp_flt <= bus.sens_temp_float;
            cap_crc     <= bus.sens_crc;
          end else if (tmo_hit) begin
            rsp0 <= RSP_TMO; rsp1 <= 8'h00; rsp2 <= 8'h00;
          end
        end
        CHECK: begin
          if (cap_err) begin
            rsp0 <= RSP_SENS; rsp1 <= 8'h00; rsp2 <= 8'h00;
          end else if (!crc_ok) begin
            rsp0 <= RSP_CRC; rsp1 <= 8'h00; rsp2 <= 8'h00;
          end else begin
            cache_valid <= 1'b1;
            c_hum_int   <= cap_hum_int;
            c_hum_flt   <= cap_hum_flt;
            c_tmp_int   <= cap_tmp_int;
            c_tmp_flt   <= cap_tmp_flt;
            rsp0        <= RSP_FRESH;
            {rsp1, rsp2} <= pick_pair(cmd, cap_hum_int, cap_hum_flt, cap_tmp_int, cap_tmp_flt);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dht_request_sequencer.sv
// Bench for dht_request_sequencer: scripted vector table, reset/boundary sequences, randomized transactions.
// Expected bytes and cycle timing come from a transaction-level model of cache, interval and timeout rules.
// Consumer backpressure is scripted or random; response bytes must stay stable while stalled.
module tb_dht_request_sequencer;
  localparam int MIN   = 2000;
  localparam int TMO   = 64;
  localparam int LIMIT = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  dht_request_sequencer_if bus();

  dht_request_sequencer #(.MIN_INTERVAL(MIN), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // sensor / consumer behaviour for the next transaction
  bit         s_resp;
  int         s_dly;
  bit         s_err;
  logic [7:0] s_f[5];
  bit         s_poke;
  bit         rdy_rand;
  int         st_byte;
  int         st_len;

  // observations
  int         o_tcmd, o_tstart, o_ttx, o_tidle, o_nstart, o_nrx;
  logic [7:0] o_rx[3];
  bit         o_unstable, o_hung, o_noisy;

  // model state and expectations
  bit         m_valid;
  logic [7:0] m_c[4];
  int         m_tgood;
  logic [23:0] e_b;
  int         e_start, e_ttx;

  typedef struct {
    logic [7:0]  cmd;
    int          gap;
    bit          resp;
    int          dly;
    bit          err;
    logic [39:0] f;
    int          st_byte;
    int          st_len;
    bit          poke;
    logic [23:0] x;
    int          xstart;
  } vec_t;

  vec_t tab[13];

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  // Transaction-level reference: cache valid for MIN cycles counted from the first
  // response cycle of a good read; sensor window is TIMEOUT cycles from START.
  task automatic predict(input logic [7:0] c, input int tc);
    logic [7:0] sum;
    e_start = 0;
    if (c != 8'h01 && c != 8'h02) begin
      e_b = 24'hEE0000; e_ttx = tc + 2;
    end else if (m_valid && (tc + 1 - m_tgood) < MIN) begin
      e_b = (c == 8'h01) ? {8'h01, m_c[0], m_c[1]} : {8'h01, m_c[2], m_c[3]};
      e_ttx = tc + 2;
    end else begin
      e_start = 1;
      if (!s_resp || s_dly >= TMO) begin
        e_b = 24'hE30000; e_ttx = tc + 2 + TMO;
      end else begin
        e_ttx = tc + 2 + s_dly + 2;
        sum = s_f[0] + s_f[1] + s_f[2] + s_f[3];
        if (s_err)              e_b = 24'hE10000;
        else if (sum != s_f[4]) e_b = 24'hE20000;
        else begin
          e_b = (c == 8'h01) ? {8'h00, s_f[0], s_f[1]} : {8'h00, s_f[2], s_f[3]};
          m_valid = 1'b1;
          for (int j = 0; j < 4; j++) m_c[j] = s_f[j];
          m_tgood = e_ttx;
        end
      end
    end
  endtask

  // Issue one command after 'gap' idle cycles, play sensor and consumer, record what happened
  task automatic do_cmd(input logic [7:0] c, input int gap);
    int fire, guard, stall, poke_at;
    bit pend;
    logic [7:0] pdat;
    o_nstart = 0; o_tstart = -1; o_ttx = -1; o_nrx = 0;
    o_unstable = 0; o_hung = 0; o_noisy = 0;
    fire = 0; stall = 0; poke_at = -1; pend = 0; pdat = 8'h00;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_byte = c; o_tcmd = cyc;
    guard = 0;
    while (o_nrx < 3 && guard < LIMIT) begin
      @(negedge clk);
      guard++;
      bus.cmd_valid = 1'b0;
      bus.sens_done = 1'b0;
      if (fire == 1) begin
        bus.sens_done = 1'b1; bus.sens_err = s_err;
        bus.sens_hum_int = s_f[0]; bus.sens_hum_float = s_f[1];
        bus.sens_temp_int = s_f[2]; bus.sens_temp_float = s_f[3]; bus.sens_crc = s_f[4];
        fire = 0;
      end else if (fire > 1) fire--;
      if (bus.sens_start) begin
        o_nstart++; o_tstart = cyc;
        if (s_resp) fire = s_dly;
        if (s_poke) poke_at = cyc + 3;
      end
      if (cyc == poke_at) begin bus.cmd_valid = 1'b1; bus.cmd_byte = 8'h01; end
      if (bus.tx_valid) begin
        if (o_ttx < 0) o_ttx = cyc;
        if (pend && bus.tx_data !== pdat) o_unstable = 1;
        if (st_len > 0 && o_nrx == st_byte && stall < st_len) begin
          bus.tx_ready = 1'b0; stall++;
        end else if (rdy_rand) bus.tx_ready = ($urandom_range(0, 2) != 0);
        else bus.tx_ready = 1'b1;
        if (bus.tx_ready) begin
          o_rx[o_nrx] = bus.tx_data; o_nrx++; pend = 0;
        end else begin
          pend = 1; pdat = bus.tx_data;
        end
      end else begin
        bus.tx_ready = rdy_rand ? ($urandom_range(0, 1) != 0) : 1'b1;
        pend = 0;
      end
    end
    if (o_nrx < 3) o_hung = 1;
    bus.sens_done = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    o_tidle = cyc;
    if (bus.busy || bus.tx_valid) o_noisy = 1;
    repeat (4) begin
      @(negedge clk);
      if (bus.busy || bus.sens_start || bus.tx_valid) o_noisy = 1;
    end
    bus.tx_ready = 1'b1;
  endtask

  task automatic judge(input string tag, input logic [23:0] xb, input int xs);
    chk({tag, " complete"}, int'(o_hung), 0);
    chk({tag, " byte0"}, 32'(o_rx[0]), 32'(xb[23:16]));
    chk({tag, " byte1"}, 32'(o_rx[1]), 32'(xb[15:8]));
    chk({tag, " byte2"}, 32'(o_rx[2]), 32'(xb[7:0]));
    chk({tag, " sens_start count"}, o_nstart, xs);
    if (xs != 0) chk({tag, " sens_start delay"}, o_tstart - o_tcmd, 2);
    chk({tag, " first tx delay"}, o_ttx - o_tcmd, e_ttx - o_tcmd);
    chk({tag, " tx_data stable"}, int'(o_unstable), 0);
    chk({tag, " idle afterwards"}, int'(o_noisy), 0);
    if (!rdy_rand && st_len == 0) chk({tag, " back to idle"}, o_tidle - o_ttx, 3);
  endtask

  task automatic load_sensor(input bit r, input int d, input bit e, input logic [39:0] f);
    s_resp = r; s_dly = d; s_err = e;
    s_f[0] = f[39:32]; s_f[1] = f[31:24]; s_f[2] = f[23:16]; s_f[3] = f[15:8]; s_f[4] = f[7:0];
  endtask

  int         seen, bad, gap, k, t0;
  logic [7:0] c;

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_byte = 8'h00; bus.sens_done = 1'b0; bus.sens_err = 1'b0;
    bus.sens_hum_int = 8'h00; bus.sens_hum_float = 8'h00; bus.sens_temp_int = 8'h00;
    bus.sens_temp_float = 8'h00; bus.sens_crc = 8'h00; bus.tx_ready = 1'b1;
    s_poke = 0; rdy_rand = 0; st_byte = -1; st_len = 0; m_valid = 0; m_tgood = 0;
    for (int j = 0; j < 4; j++) m_c[j] = 8'h00;
    load_sensor(1'b1, 5, 1'b0, 40'h37_00_18_05_54);

    //                cmd    gap  resp dly    err  hi hf ti tf crc         stb len poke expected      starts
    tab[0]  = '{8'h01,    2, 1'b1, 5,     1'b0, 40'h37_00_18_05_55, -1, 0,  1'b0, 24'hE2_00_00, 1};
    tab[1]  = '{8'h02,   10, 1'b1, 5,     1'b0, 40'h37_00_18_05_54, -1, 0,  1'b0, 24'h00_18_05, 1};
    tab[2]  = '{8'h01, 1000, 1'b1, 5,     1'b0, 40'h37_00_18_05_54, -1, 0,  1'b0, 24'h01_37_00, 0};
    tab[3]  = '{8'h02,    5, 1'b1, 5,     1'b0, 40'h37_00_18_05_54,  1, 50, 1'b0, 24'h01_18_05, 0};
    tab[4]  = '{8'h7A,    3, 1'b1, 5,     1'b0, 40'h37_00_18_05_54, -1, 0,  1'b0, 24'hEE_00_00, 0};
    tab[5]  = '{8'h00,    3, 1'b1, 5,     1'b0, 40'h37_00_18_05_54, -1, 0,  1'b0, 24'hEE_00_00, 0};
    tab[6]  = '{8'h03,    3, 1'b1, 5,     1'b0, 40'h37_00_18_05_54, -1, 0,  1'b0, 24'hEE_00_00, 0};
    tab[7]  = '{8'h01, 2100, 1'b0, 5,     1'b0, 40'h37_00_18_05_54, -1, 0,  1'b0, 24'hE3_00_00, 1};
    tab[8]  = '{8'h01,    3, 1'b1, 3,     1'b1, 40'h37_00_18_05_54, -1, 0,  1'b0, 24'hE1_00_00, 1};
    tab[9]  = '{8'h02,    3, 1'b1, TMO-1, 1'b0, 40'h40_02_19_07_62, -1, 0,  1'b0, 24'h00_19_07, 1};
    tab[10] = '{8'h01, 2100, 1'b1, TMO,   1'b0, 40'h40_02_19_07_62, -1, 0,  1'b0, 24'hE3_00_00, 1};
    tab[11] = '{8'h01,    5, 1'b1, 20,    1'b0, 40'h40_02_19_07_62, -1, 0,  1'b1, 24'h00_40_02, 1};
    tab[12] = '{8'h02,    3, 1'b1, 20,    1'b0, 40'h40_02_19_07_62, -1, 0,  1'b0, 24'h01_19_07, 0};

    // reset state
    repeat (3) @(negedge clk);
    chk("reset outputs", 32'({bus.sens_start, bus.tx_valid, bus.busy, bus.tx_data}), 0);
    rst = 1'b0;

    // scripted scenarios
    for (int i = 0; i < 13; i++) begin
      load_sensor(tab[i].resp, tab[i].dly, tab[i].err, tab[i].f);
      st_byte = tab[i].st_byte; st_len = tab[i].st_len; s_poke = tab[i].poke; rdy_rand = 0;
      do_cmd(tab[i].cmd, tab[i].gap);
      predict(tab[i].cmd, o_tcmd);
      judge($sformatf("row%0d", i), tab[i].x, tab[i].xstart);
    end
    st_byte = -1; st_len = 0; s_poke = 0;

    // reset while waiting for the sensor: abort, then ignore the late sens_done
    repeat (MIN + 100) @(negedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_byte = 8'h02;
    seen = 0;
    for (int j = 0; j < 8 && seen == 0; j++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (bus.sens_start) seen = 1;
    end
    chk("rstwait sens_start", seen, 1);
    repeat (10) @(negedge clk);
    chk("rstwait busy", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstwait outputs", 32'({bus.sens_start, bus.tx_valid, bus.busy, bus.tx_data}), 0);
    rst = 1'b0; m_valid = 0;
    @(negedge clk);
    bus.sens_done = 1'b1; bus.sens_err = 1'b0;
    bus.sens_hum_int = 8'h37; bus.sens_hum_float = 8'h00; bus.sens_temp_int = 8'h18;
    bus.sens_temp_float = 8'h05; bus.sens_crc = 8'h54;
    bad = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      bus.sens_done = 1'b0;
      if (bus.busy || bus.sens_start || bus.tx_valid) bad = 1;
    end
    chk("rstwait late done ignored", bad, 0);
    // reset must have invalidated the cache
    load_sensor(1'b1, 7, 1'b0, 40'h37_00_18_05_54);
    do_cmd(8'h01, 3);
    predict(8'h01, o_tcmd);
    judge("post-reset read", 24'h00_37_00, 1);

    // interval boundary: last hit one cycle before expiry, miss at expiry
    load_sensor(1'b1, 4, 1'b0, 40'h11_22_33_44_AA);
    do_cmd(8'h01, 2100);
    predict(8'h01, o_tcmd);
    judge("bnd fill a", e_b, e_start);
    t0 = o_ttx;
    do_cmd(8'h02, t0 + MIN - 2 - cyc - 1);
    predict(8'h02, o_tcmd);
    judge("bnd last hit", 24'h01_33_44, 0);
    do_cmd(8'h01, 2100);
    predict(8'h01, o_tcmd);
    judge("bnd fill b", e_b, e_start);
    t0 = o_ttx;
    do_cmd(8'h02, t0 + MIN - 1 - cyc - 1);
    predict(8'h02, o_tcmd);
    judge("bnd expired", 24'h00_33_44, 1);

    // randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 9));
      if (k < 4)      c = 8'h01;
      else if (k < 8) c = 8'h02;
      else            c = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) gap = 2050 + int'($urandom_range(0, 50));
      else                           gap = int'($urandom_range(0, 20));
      s_resp = ($urandom_range(0, 9) != 0);
      s_dly  = int'($urandom_range(1, TMO));
      s_err  = ($urandom_range(0, 9) == 0);
      for (int j = 0; j < 4; j++) s_f[j] = 8'($urandom_range(0, 255));
      s_f[4] = s_f[0] + s_f[1] + s_f[2] + s_f[3];
      if ($urandom_range(0, 4) == 0) s_f[4] = s_f[4] + 8'($urandom_range(1, 255));
      rdy_rand = ($urandom_range(0, 1) != 0);
      s_poke   = ($urandom_range(0, 3) == 0);
      do_cmd(c, gap);
      predict(c, o_tcmd);
      judge($sformatf("rnd%0d", i), e_b, e_start);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
